fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program counter and instruction-memory address width.
REQ-002 SHALL have parameter INST_W, default 16, meaning instruction word width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port clk_en  input  1  pipeline advance; decode consumes the head instruction when high.
REQ-006 SHALL have port sync_rst  input  1  synchronous restart of fetch at address 0.
REQ-007 SHALL have port branch_taken  input  1  redirect request.
REQ-008 SHALL have port branch_target  input  PC_W  redirect address.
REQ-009 SHALL have port imem_req  output  1  one-cycle read request pulse.
REQ-010 SHALL have port imem_addr  output  PC_W  read address, valid while imem_req is high.
REQ-011 SHALL have port imem_ack  input  1  read response strobe, arriving 1 or more cycles after imem_req.
REQ-012 SHALL have port imem_data  input  INST_W  read data, valid while imem_ack is high.
REQ-013 SHALL have port inst_bus  output  INST_W  instruction presented to decode.
REQ-014 SHALL have port invalidate  output  1  high means inst_bus is a bubble.
REQ-015 SHALL have port pc_out  output  PC_W  PC of the instruction on inst_bus.

Function
REQ-016 SHALL hold an instruction buffer of depth D (see Configuration); each entry stores {instruction, PC}.
REQ-017 SHALL allow at most one outstanding imem request.
REQ-018 SHALL assert imem_req only when all of the following hold: nothing is outstanding, buffer occupancy < D, branch_taken=0, sync_rst=0.
REQ-019 SHALL drive imem_addr=fetch_pc on each request, then set fetch_pc to fetch_pc+1 modulo 2^PC_W, so that 2^PC_W-1 wraps to 0.
REQ-020 SHALL write imem_data, tagged with the request PC, into the buffer tail on a non-stale imem_ack; the entry is visible on inst_bus from the next cycle (no bypass).
REQ-021 SHALL pop the buffer head when clk_en=1, the buffer is non-empty, branch_taken=0 and sync_rst=0.
REQ-022 SHALL drive inst_bus/pc_out from the buffer head with invalidate=0 when the buffer is non-empty; otherwise it SHALL drive inst_bus=0 (NOP), pc_out=0 and invalidate=1.
REQ-023 SHALL, on branch_taken=1 with sync_rst=0, load fetch_pc=branch_target, empty the buffer, and mark any outstanding request stale.
REQ-024 SHALL, on sync_rst=1, behave as a redirect to address 0; sync_rst SHALL have priority over branch_taken.
REQ-025 SHALL force invalidate=1 and inst_bus=0 combinationally during any cycle with branch_taken=1 or sync_rst=1.
REQ-026 SHALL discard an imem_ack that returns for a stale request, or that arrives in a redirect cycle; the discard SHALL clear the outstanding flag without a buffer write.
REQ-027 SHALL hold the buffer contents and head while clk_en=0; requests and responses SHALL continue while buffer space allows.
REQ-028 SHALL accept a simultaneous pop and ack in the same cycle; occupancy is unchanged in that cycle.
REQ-029 SHALL ignore imem_ack when nothing is outstanding.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously set: fetch_pc=0, buffer empty, outstanding=0, stale=0, imem_req=0, imem_addr=0, inst_bus=0, pc_out=0, invalidate=1.
REQ-031 SHALL issue the first request in the first clock cycle after rst_n deasserts; with a 1-cycle imem, the first instruction appears with invalidate=0 two cycles after that.

Configuration
REQ-032 SHALL, with macro FETCH_PREFETCH_EN defined, use D=2 and issue a new request as soon as occupancy+outstanding < 2.
REQ-033 SHALL, without FETCH_PREFETCH_EN, use D=1 and issue a request only when the buffer is empty.

Verification
REQ-034 SHALL cover reset release: 1-cycle imem, clk_en=1 -> requests to addresses 0,1,2...; inst_bus shows mem[0] at cycle 3, then one instruction per cycle with FETCH_PREFETCH_EN.
REQ-035 SHALL cover redirect: branch_taken with target 0x155 while one request is outstanding -> the stale ack is dropped, invalidate=1 in the redirect cycle, the next request uses address 0x155, and pc_out=0x155 on the first valid instruction.
REQ-036 SHALL cover stall: clk_en=0 for 5 cycles -> occupancy saturates at D, imem_req stays low, and inst_bus is stable; on release, instructions appear in order with no loss.
REQ-037 SHALL cover wrap: fetch_pc=0x3FF -> the request after 0x3FF uses address 0x000.
REQ-038 SHALL cover a 3-cycle imem latency: invalidate pulses between instructions, no request is issued while one is outstanding, and ordering is preserved.
REQ-039 SHALL cover asynchronous reset mid-fetch: rst_n low between clock edges -> outputs go immediately to their reset values, and a late ack is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch front end.
//
// Issues single-word reads to instruction memory (one outstanding at a time),
// buffers returned words tagged with their PC, and presents the buffer head
// to decode. Branch redirects and synchronous restarts flush the buffer and
// poison any in-flight read so its late response is dropped.
//
// Build option: define FETCH_PREFETCH_EN for a 2-entry buffer that keeps a
// read in flight while decode drains, sustaining one instruction per cycle
// with a 1-cycle memory. Without it the buffer holds a single entry.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clk_en               decode consumes the head instruction when high
//   sync_rst             synchronous restart at address 0 (beats branch_taken)
//   branch_taken/_target redirect request and address
//   imem_req/imem_addr   one-cycle read request and its address
//   imem_ack/imem_data   read response strobe and data
//   inst_bus/pc_out      head instruction and its PC
//   invalidate           high when inst_bus carries a bubble
module fetch_stage #(
  parameter int PC_W   = 10,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              sync_rst,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst_bus,
  output logic              invalidate,
  output logic [PC_W-1:0]   pc_out
);

`ifdef FETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int PTR_W = (D > 1) ? $clog2(D) : 1;
  localparam int CNT_W = $clog2(D + 1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t           buf_q [D];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] occ_q;
  logic [PC_W-1:0]  fetch_pc_q;
  logic [PC_W-1:0]  req_pc_q;   // PC of the in-flight read
  logic             outst_q;
  logic             stale_q;

  logic             redirect;
  logic             empty;
  logic             ack_now;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] occ_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    redirect = branch_taken | sync_rst;
    empty    = (occ_q == '0);
    ack_now  = imem_ack & outst_q;            // strobes with nothing in flight are noise
    push     = ack_now & ~stale_q & ~redirect;
    pop      = clk_en & ~empty & ~redirect;
    // Occupancy as it will be after this edge. Counting the landing ack and
    // the departing head lets the next read go out in the ack cycle, which is
    // what keeps a 1-cycle memory streaming at full rate.
    occ_eff  = occ_q + CNT_W'(push) - CNT_W'(pop);
    // rst_n gate keeps the request low while reset is held.
    imem_req = rst_n & ~redirect & ~(outst_q & ~ack_now) & (occ_eff < CNT_W'(D));
    imem_addr = fetch_pc_q;
  end

  always_comb begin
    invalidate = empty | redirect;
    inst_bus   = invalidate ? '0 : buf_q[head_q].inst;
    pc_out     = empty ? '0 : buf_q[head_q].pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      outst_q    <= 1'b0;
      stale_q    <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q <= sync_rst ? '0 : branch_target;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      // An ack landing in this cycle retires the read (its data is dropped);
      // otherwise the read stays in flight but its response is poisoned.
      outst_q    <= outst_q & ~imem_ack;
      stale_q    <= outst_q & ~imem_ack;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      occ_q <= occ_eff;
      if (imem_req) begin
        fetch_pc_q <= fetch_pc_q + PC_W'(1);
        req_pc_q   <= fetch_pc_q;
        outst_q    <= 1'b1;
        stale_q    <= 1'b0;
      end else if (ack_now) begin
        outst_q    <= 1'b0;
        stale_q    <= 1'b0;
      end
    end
  end

  // Storage needs no reset: entries are only read while occupancy says valid.
  always_ff @(posedge clk) begin
    if (push) buf_q[tail_q] <= '{inst: imem_data, pc: req_pc_q};
  end

endmodule
